gpu_command_dispatcher: RTL and testbench
=========================================

GPU_COMMAND_DISPATCHER -- requirements
Module: gpu_command_dispatcher

Interface
REQ-001: Parameter DEPTH, default 4, command FIFO depth in entries; power of two, >= 2.
REQ-002: Coordinate widths use `WIDTH_BITS (x) and `HEIGHT_BITS (y) from source/gpu_definitions.vh.
REQ-003: clk  input  1  sole clock; all state on rising edge.
REQ-004: rst  input  1  asynchronous, active-high reset.
REQ-005: cmd_valid  input  1  command present on cmd_* this cycle.
REQ-006: cmd_ready  output  1  FIFO can accept a command.
REQ-007: cmd_op  input  2  00 line, 01 fill, 10 arc, 11 reserved.
REQ-008: cmd_x0, cmd_x1  input  `WIDTH_BITS each  operand x coordinates.
REQ-009: cmd_y0, cmd_y1  input  `HEIGHT_BITS each  operand y coordinates.
REQ-010: x0_o, x1_o  output  `WIDTH_BITS; y0_o, y1_o  output  `HEIGHT_BITS  operands of the dispatched command, shared by all units.
REQ-011: line_start, fill_start, arc_start  output  1 each  one-cycle start pulse to the selected unit.
REQ-012: line_done, fill_done, arc_done  input  1 each  completion pulse from the unit.
REQ-013: line_active, fill_active, arc_active  output  1 each  one-hot ownership flags consumed by the pixel output mux.
REQ-014: busy  output  1  FSM not IDLE or FIFO non-empty.
REQ-015: bad_op  output  1  one-cycle pulse when a reserved op is discarded.
REQ-016: cmd_count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017: Push occurs when cmd_valid && cmd_ready; cmd_ready = (cmd_count != DEPTH), independent of same-cycle pop.
REQ-018: FIFO stores {op, x0, y0, x1, y1}; read/write pointers wrap modulo DEPTH; push and pop in same cycle leave cmd_count unchanged.
REQ-019: FSM states IDLE, START, RUN.
REQ-020: IDLE, FIFO empty: remain IDLE.
REQ-021: IDLE, FIFO non-empty, head op in {00,01,10}: pop, latch operands into x0_o..y1_o and op into a select register, go START.
REQ-022: IDLE, head op = 11: pop and discard, pulse bad_op this cycle, operand outputs unchanged, remain IDLE.
REQ-023: START (exactly one cycle): assert the selected *_start; set the selected *_active; go RUN.
REQ-024: RUN: hold selected *_active; on the selected *_done go IDLE and clear *_active on that edge.
REQ-025: *_done of a non-selected unit, or any *_done in IDLE/START, is ignored.
REQ-026: At most one *_active and at most one *_start high in any cycle.
REQ-027: Latency: command pushed at edge N into empty FIFO with FSM IDLE -> popped in cycle N+1 -> *_start and *_active high in cycle N+2.
REQ-028: Back-to-back: done seen at edge M -> IDLE in cycle M+1 (pops next) -> next *_start in cycle M+2; no cycle with two actives.
REQ-029: x0_o..y1_o change only on a dispatching pop; stable throughout START and RUN.
REQ-030: Pushes continue during START/RUN until full; push at full is dropped without state change.

Reset
REQ-031: On rst: FSM IDLE; FIFO empty, pointers 0; cmd_count 0; cmd_ready 1; all *_start, *_active, bad_op 0; busy 0; x0_o, y0_o, x1_o, y1_o 0.
REQ-032: rst asserted mid-operation aborts the command and discards all queued entries; no start pulse in the first cycle after release.

Verification
REQ-033: Push line (0,0)->(10,5) at edge 0, line_done pulsed in cycle 6 -> line_start only in cycle 2; line_active high cycles 2-6; busy low from cycle 7.
REQ-034: Push fill, arc, line back-to-back; done pulsed 3 cycles after each start -> start pulses 2 cycles after each done; active one-hot at all times; order fill, arc, line.
REQ-035: DEPTH=4, hold first command in RUN, push 6 -> cmd_ready low after 4 queued, 5th/6th dropped, cmd_count=4.
REQ-036: Push op=11 then fill -> bad_op pulse in cycle 1, no start; fill_start in cycle 3.
REQ-037: Arc running, pulse line_done and fill_done -> ignored, arc_active stays high until arc_done.
REQ-038: rst during RUN with 3 queued -> all outputs at reset values, cmd_count 0, no start after release.

Source files
------------

// File: rtl/gpu_command_dispatcher.sv
// Command dispatcher: queues draw commands in a small FIFO and hands them one at
// a time to the line, fill and arc units, tracking which unit owns the pixel bus.

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif

module gpu_command_dispatcher #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,

  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_op,
  input  logic [`WIDTH_BITS-1:0]   cmd_x0,
  input  logic [`WIDTH_BITS-1:0]   cmd_x1,
  input  logic [`HEIGHT_BITS-1:0]  cmd_y0,
  input  logic [`HEIGHT_BITS-1:0]  cmd_y1,

  output logic [`WIDTH_BITS-1:0]   x0_o,
  output logic [`WIDTH_BITS-1:0]   x1_o,
  output logic [`HEIGHT_BITS-1:0]  y0_o,
  output logic [`HEIGHT_BITS-1:0]  y1_o,

  output logic                     line_start,
  output logic                     fill_start,
  output logic                     arc_start,
  input  logic                     line_done,
  input  logic                     fill_done,
  input  logic                     arc_done,
  output logic                     line_active,
  output logic                     fill_active,
  output logic                     arc_active,

  output logic                     busy,
  output logic                     bad_op,
  output logic [$clog2(DEPTH):0]   cmd_count
);

  localparam int WB      = `WIDTH_BITS;
  localparam int HB      = `HEIGHT_BITS;
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 2 + 2 * WB + 2 * HB;

  // Entry layout, MSB to LSB: {op, x0, y0, x1, y1}
  localparam int Y1_LSB = 0;
  localparam int X1_LSB = HB;
  localparam int Y0_LSB = HB + WB;
  localparam int X0_LSB = 2 * HB + WB;
  localparam int OP_LSB = 2 * HB + 2 * WB;

  localparam logic [1:0] OP_LINE = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b01;
  localparam logic [1:0] OP_ARC  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_START = 2'b01,
    S_RUN   = 2'b10
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           sel_op;

  logic [ENTRY_W-1:0]   fifo_mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;

  logic                 push;
  logic                 pop;
  logic                 dispatch;
  logic                 fifo_empty;
  logic [ENTRY_W-1:0]   head;
  logic [1:0]           head_op;
  logic                 sel_done;

  // Completion from the unit currently owning the bus; other done pulses are noise.
  function automatic logic done_of(input logic [1:0] op, input logic l_done,
                                   input logic f_done, input logic a_done);
    case (op)
      OP_LINE: done_of = l_done;
      OP_FILL: done_of = f_done;
      OP_ARC:  done_of = a_done;
      default: done_of = 1'b0;
    endcase
  endfunction

  // ---- command FIFO ----
  assign cmd_ready  = (count != CNT_W'(DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = cmd_valid && cmd_ready;
  assign head       = fifo_mem[rd_ptr];
  assign head_op    = head[OP_LSB +: 2];
  assign cmd_count  = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_op, cmd_x0, cmd_y0, cmd_x1, cmd_y1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---- dispatch FSM ----
  assign sel_done = done_of(sel_op, line_done, fill_done, arc_done);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    dispatch  = 1'b0;
    bad_op    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_op == OP_RSVD) begin
            bad_op = 1'b1;
          end else begin
            dispatch  = 1'b1;
            state_nxt = S_START;
          end
        end
      end
      S_START: state_nxt = S_RUN;
      S_RUN: begin
        if (sel_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      sel_op <= OP_LINE;
      x0_o   <= '0;
      y0_o   <= '0;
      x1_o   <= '0;
      y1_o   <= '0;
    end else begin
      state <= state_nxt;
      if (dispatch) begin
        sel_op <= head_op;
        x0_o   <= head[X0_LSB +: WB];
        y0_o   <= head[Y0_LSB +: HB];
        x1_o   <= head[X1_LSB +: WB];
        y1_o   <= head[Y1_LSB +: HB];
      end
    end
  end

  // ---- unit handshake outputs, decoded from one state and one select so they stay one-hot ----
  assign line_start  = (state == S_START) && (sel_op == OP_LINE);
  assign fill_start  = (state == S_START) && (sel_op == OP_FILL);
  assign arc_start   = (state == S_START) && (sel_op == OP_ARC);

  assign line_active = (state != S_IDLE) && (sel_op == OP_LINE);
  assign fill_active = (state != S_IDLE) && (sel_op == OP_FILL);
  assign arc_active  = (state != S_IDLE) && (sel_op == OP_ARC);

  assign busy = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_gpu_command_dispatcher.sv
// Directed bench for gpu_command_dispatcher: latency, back-to-back dispatch,
// FIFO full, reserved op, ignored done pulses and mid-run reset.

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif

module tb_gpu_command_dispatcher;

  localparam int DEPTH = 4;
  localparam logic [1:0] OP_LINE = 2'b00;
  localparam logic [1:0] OP_FILL = 2'b01;
  localparam logic [1:0] OP_ARC  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  logic                    clk;
  logic                    rst;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_op;
  logic [`WIDTH_BITS-1:0]  cmd_x0, cmd_x1;
  logic [`HEIGHT_BITS-1:0] cmd_y0, cmd_y1;
  logic [`WIDTH_BITS-1:0]  x0_o, x1_o;
  logic [`HEIGHT_BITS-1:0] y0_o, y1_o;
  logic                    line_start, fill_start, arc_start;
  logic                    line_done, fill_done, arc_done;
  logic                    line_active, fill_active, arc_active;
  logic                    busy;
  logic                    bad_op;
  logic [$clog2(DEPTH):0]  cmd_count;

  int checks;
  int errors;

  gpu_command_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .x0_o(x0_o), .x1_o(x1_o), .y0_o(y0_o), .y1_o(y1_o),
    .line_start(line_start), .fill_start(fill_start), .arc_start(arc_start),
    .line_done(line_done), .fill_done(fill_done), .arc_done(arc_done),
    .line_active(line_active), .fill_active(fill_active), .arc_active(arc_active),
    .busy(busy), .bad_op(bad_op), .cmd_count(cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cmd(input logic [1:0] op, input int x0, input int y0,
                         input int x1, input int y1);
    cmd_op = op;
    cmd_x0 = x0[`WIDTH_BITS-1:0];
    cmd_y0 = y0[`HEIGHT_BITS-1:0];
    cmd_x1 = x1[`WIDTH_BITS-1:0];
    cmd_y1 = y1[`HEIGHT_BITS-1:0];
  endtask

  logic [2:0] exp_start, exp_act;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    cmd_valid = 1'b0;
    set_cmd(OP_LINE, 0, 0, 0, 0);
    line_done = 1'b0;
    fill_done = 1'b0;
    arc_done  = 1'b0;

    // Reset values
    repeat (2) tick();
    chk("rst_count", cmd_count, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_active", {line_active, fill_active, arc_active}, 0);
    chk("rst_start", {line_start, fill_start, arc_start}, 0);
    chk("rst_bad_op", bad_op, 0);
    chk("rst_operands", {x0_o, y0_o, x1_o, y1_o}, 0);
    rst = 1'b0;
    tick();

    // Single line (0,0)->(10,5): push at edge 0, done in cycle 6
    set_cmd(OP_LINE, 0, 0, 10, 5);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    chk("lat_c1_start", line_start, 0);
    chk("lat_c1_count", cmd_count, 1);
    chk("lat_c1_busy", busy, 1);
    tick();
    chk("lat_c2_start", line_start, 1);
    chk("lat_c2_active", line_active, 1);
    chk("lat_c2_x1", x1_o, 10);
    chk("lat_c2_y1", y1_o, 5);
    chk("lat_c2_count", cmd_count, 0);
    for (int c = 3; c <= 6; c++) begin
      tick();
      if (c == 6) line_done = 1'b1;
      chk("lat_run_start", line_start, 0);
      chk("lat_run_active", line_active, 1);
    end
    tick();
    line_done = 1'b0;
    chk("lat_c7_active", line_active, 0);
    chk("lat_c7_busy", busy, 0);

    // Back-to-back fill, arc, line; each done 3 cycles after its start
    for (int c = 0; c <= 17; c++) begin
      cmd_valid = (c <= 2);
      if (c == 0) set_cmd(OP_FILL, 1, 1, 2, 2);
      else if (c == 1) set_cmd(OP_ARC, 3, 3, 4, 4);
      else set_cmd(OP_LINE, 5, 5, 6, 6);
      fill_done = (c == 5);
      arc_done  = (c == 10);
      line_done = (c == 15);
      exp_start = (c == 2) ? 3'b010 : (c == 7) ? 3'b001 : (c == 12) ? 3'b100 : 3'b000;
      exp_act   = (c >= 2 && c <= 5) ? 3'b010 :
                  (c >= 7 && c <= 10) ? 3'b001 :
                  (c >= 12 && c <= 15) ? 3'b100 : 3'b000;
      chk("b2b_start", {line_start, fill_start, arc_start}, exp_start);
      chk("b2b_active", {line_active, fill_active, arc_active}, exp_act);
      tick();
    end
    cmd_valid = 1'b0;
    fill_done = 1'b0;
    arc_done  = 1'b0;
    line_done = 1'b0;
    chk("b2b_busy_end", busy, 0);

    // FIFO full: hold a line in RUN, offer 6 fills
    set_cmd(OP_LINE, 0, 0, 1, 1);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("full_line_run", line_active, 1);
    for (int i = 0; i < 6; i++) begin
      set_cmd(OP_FILL, 100 + i, 0, 0, 0);
      cmd_valid = 1'b1;
      chk("full_ready", cmd_ready, (i < 4) ? 1 : 0);
      tick();
    end
    cmd_valid = 1'b0;
    chk("full_count", cmd_count, 4);
    chk("full_ready_low", cmd_ready, 0);
    chk("full_line_held", line_active, 1);
    line_done = 1'b1;
    tick();
    line_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 8 && !fill_start; k++) tick();
      chk("drain_start", fill_start, 1);
      chk("drain_x0", x0_o, 100 + i);
      tick();
      fill_done = 1'b1;
      tick();
      fill_done = 1'b0;
    end
    repeat (3) tick();
    chk("drain_count", cmd_count, 0);
    chk("drain_busy", busy, 0);

    // Reserved op then fill
    set_cmd(OP_RSVD, 55, 55, 55, 55);
    cmd_valid = 1'b1;
    tick();
    chk("rsvd_bad_op", bad_op, 1);
    chk("rsvd_no_start", {line_start, fill_start, arc_start}, 0);
    set_cmd(OP_FILL, 7, 8, 9, 10);
    tick();
    cmd_valid = 1'b0;
    chk("rsvd_c2_bad_op", bad_op, 0);
    chk("rsvd_operands_kept", x0_o, 103);
    chk("rsvd_c2_no_start", fill_start, 0);
    tick();
    chk("rsvd_fill_start", fill_start, 1);
    chk("rsvd_fill_x0", x0_o, 7);
    chk("rsvd_fill_y1", y1_o, 10);
    tick();
    fill_done = 1'b1;
    tick();
    fill_done = 1'b0;
    chk("rsvd_fill_done", fill_active, 0);

    // Arc ignores foreign done pulses and its own done during START
    set_cmd(OP_ARC, 9, 9, 9, 9);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("arc_start", arc_start, 1);
    arc_done = 1'b1;
    tick();
    arc_done = 1'b0;
    chk("arc_done_in_start_ignored", arc_active, 1);
    line_done = 1'b1;
    fill_done = 1'b1;
    tick();
    line_done = 1'b0;
    fill_done = 1'b0;
    chk("arc_foreign_done", {line_active, fill_active, arc_active}, 3'b001);
    tick();
    chk("arc_still_active", arc_active, 1);
    arc_done = 1'b1;
    tick();
    arc_done = 1'b0;
    chk("arc_cleared", arc_active, 0);
    chk("arc_idle", busy, 0);

    // Reset during RUN with 3 queued
    set_cmd(OP_ARC, 20, 21, 22, 23);
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      set_cmd(OP_FILL, 30 + i, 0, 0, 0);
      cmd_valid = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("mrst_pre_count", cmd_count, 3);
    chk("mrst_pre_active", arc_active, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_count", cmd_count, 0);
    chk("mrst_ready", cmd_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_active", {line_active, fill_active, arc_active}, 0);
    chk("mrst_operands", {x0_o, y0_o, x1_o, y1_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mrst_post_start", {line_start, fill_start, arc_start}, 0);
      chk("mrst_post_count", cmd_count, 0);
      chk("mrst_post_busy", busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
